// File: rtl/alu_64.sv
// 64-bit add/sub/AND/XOR execute-stage ALU with a one-cycle registered result and signed-overflow flag.
// Define ALU_64_FLAGS_EN to add the registered zero and sign flags for the condition-code register.
module alu_64 (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         control_signal,
  input  logic signed [63:0] a,
  input  logic signed [63:0] b,
  output logic signed [63:0] op_out,
  output logic               overflow
`ifdef ALU_64_FLAGS_EN
  ,
  output logic               zero,
  output logic               sign
`endif
);

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  // Signed overflow: the result sign disagrees with what the operand signs require.
  function automatic logic f_ovf(input logic is_sub, input logic sa, input logic sb,
                                 input logic sr);
    logic same_sign;
    same_sign = is_sub ? (sa != sb) : (sa == sb);
    return same_sign && (sr != sa);
  endfunction

  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_diff;
  logic signed [DATA_W-1:0] w_result;
  logic                     w_ovf;

  assign w_sum  = a + b;
  assign w_diff = a + ~b + 64'sd1;

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (op_e'(control_signal))
      OP_ADD: begin
        w_result = w_sum;
        w_ovf    = f_ovf(1'b0, a[DATA_W-1], b[DATA_W-1], w_sum[DATA_W-1]);
      end
      OP_SUB: begin
        w_result = w_diff;
        w_ovf    = f_ovf(1'b1, a[DATA_W-1], b[DATA_W-1], w_diff[DATA_W-1]);
      end
      OP_AND: w_result = a & b;
      OP_XOR: w_result = a ^ b;
      default: begin
        w_result = '0;
        w_ovf    = 1'b0;
      end
    endcase
  end

  // Stage p0: registered result and flags.
  logic signed [DATA_W-1:0] r_result_p0;
  logic                     r_ovf_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result_p0 <= '0;
      r_ovf_p0    <= 1'b0;
    end else begin
      r_result_p0 <= w_result;
      r_ovf_p0    <= w_ovf;
    end
  end

  assign op_out   = r_result_p0;
  assign overflow = r_ovf_p0;

`ifdef ALU_64_FLAGS_EN
  logic r_zero_p0;
  logic r_sign_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero_p0 <= 1'b1;
      r_sign_p0 <= 1'b0;
    end else begin
      r_zero_p0 <= (w_result == '0);
      r_sign_p0 <= w_result[DATA_W-1];
    end
  end

  assign zero = r_zero_p0;
  assign sign = r_sign_p0;
`endif

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed vectors, randomized ops against a wide-arithmetic model,
// and a back-to-back stream with a mid-stream reset.
module tb_alu_64;

  logic               clk;
  logic               rst;
  logic [1:0]         control_signal;
  logic signed [63:0] a;
  logic signed [63:0] b;
  logic signed [63:0] op_out;
  logic               overflow;
`ifdef ALU_64_FLAGS_EN
  logic               zero;
  logic               sign;
`endif

  int total = 0;
  int bad   = 0;

  alu_64 dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .a              (a),
    .b              (b),
    .op_out         (op_out),
    .overflow       (overflow)
`ifdef ALU_64_FLAGS_EN
    ,
    .zero           (zero),
    .sign           (sign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: do the arithmetic one bit wider; overflow means the true value does not fit in 64 bits.
  function automatic void model(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic v);
    logic [64:0] wide;
    wide = '0;
    v    = 1'b0;
    case (op)
      2'd0: begin wide = {x[63], x} + {y[63], y}; r = wide[63:0]; v = wide[64] != wide[63]; end
      2'd1: begin wide = {x[63], x} - {y[63], y}; r = wide[63:0]; v = wide[64] != wide[63]; end
      2'd2: r = x & y;
      default: r = x ^ y;
    endcase
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return 64'h1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drive(input logic [1:0] op, input logic [63:0] x, input logic [63:0] y,
                       input logic r);
    @(negedge clk);
    control_signal = op;
    a   = x;
    b   = y;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
    drive(2'd3, 64'h1234, 64'h5678, 1'b1);
    total++;
    if (op_out !== 64'h0) begin
      bad++;
      $display("FAIL reset_op_out got=%h want=%h", op_out, 64'h0);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_overflow got=%b want=0", overflow);
    end
`ifdef ALU_64_FLAGS_EN
    total++;
    if (zero !== 1'b1 || sign !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got zero=%b sign=%b want zero=1 sign=0", zero, sign);
    end
`endif
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] res;
    logic        ovf;
  } vec_t;

  task automatic test_directed();
    vec_t v[9];
    v[0] = '{2'd1, 64'd256, 64'd52, 64'd204, 1'b0};
    v[1] = '{2'd0, -64'sd456, -64'sd154, -64'sd610, 1'b0};
    v[2] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b1};
    v[3] = '{2'd1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    v[4] = '{2'd1, 64'hABCD_ABCD_ABCD_ABCD, 64'hABCD_ABCD_ABCD_ABCD, 64'h0, 1'b0};
    v[5] = '{2'd2, 64'h5AA, 64'hFFF, 64'h5AA, 1'b0};
    v[6] = '{2'd2, 64'h5AA, 64'h0, 64'h0, 1'b0};
    v[7] = '{2'd3, 64'h42A, 64'hFFF, 64'hBD5, 1'b0};
    v[8] = '{2'd3, 64'h32A, 64'hFFF, 64'hCD5, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(v[i].op, v[i].x, v[i].y, 1'b0);
      total++;
      if (op_out !== v[i].res || overflow !== v[i].ovf) begin
        bad++;
        $display("FAIL directed_%0d got=%h/%b want=%h/%b", i, op_out, overflow, v[i].res, v[i].ovf);
      end
`ifdef ALU_64_FLAGS_EN
      total++;
      if (zero !== (v[i].res == 64'h0) || sign !== v[i].res[63]) begin
        bad++;
        $display("FAIL directed_flags_%0d got zero=%b sign=%b want zero=%b sign=%b",
                 i, zero, sign, v[i].res == 64'h0, v[i].res[63]);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [63:0] x, y, er;
    logic        ev;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = pick_operand();
      y  = pick_operand();
      model(op, x, y, er, ev);
      drive(op, x, y, 1'b0);
      total++;
      if (op_out !== er || overflow !== ev) begin
        bad++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got=%h/%b want=%h/%b",
                 i, op, x, y, op_out, overflow, er, ev);
      end
`ifdef ALU_64_FLAGS_EN
      total++;
      if (zero !== (er == 64'h0) || sign !== er[63]) begin
        bad++;
        $display("FAIL random_flags_%0d got zero=%b sign=%b", i, zero, sign);
      end
`endif
    end
  endtask

  // Inputs change every cycle; each negedge checks the edge that just passed, then presents the next op.
  task automatic test_back_to_back();
    logic [63:0] er, x, y;
    logic        ev, have;
    logic [1:0]  op;
    logic        r;
    have = 1'b0;
    er   = '0;
    ev   = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (have) begin
        total++;
        if (op_out !== er || overflow !== ev) begin
          bad++;
          $display("FAIL b2b_%0d got=%h/%b want=%h/%b", i, op_out, overflow, er, ev);
        end
`ifdef ALU_64_FLAGS_EN
        total++;
        if (zero !== (er == 64'h0) || sign !== er[63]) begin
          bad++;
          $display("FAIL b2b_flags_%0d got zero=%b sign=%b", i, zero, sign);
        end
`endif
      end
      op = 2'($urandom_range(0, 3));
      x  = pick_operand();
      y  = pick_operand();
      r  = (i == 12);
      if (x == 64'h0) x = 64'h3;
      control_signal = op;
      a   = x;
      b   = y;
      rst = r;
      if (r) begin
        er = '0;
        ev = 1'b0;
      end else begin
        model(op, x, y, er, ev);
      end
      have = 1'b1;
    end
    @(negedge clk);
    total++;
    if (op_out !== er || overflow !== ev) begin
      bad++;
      $display("FAIL b2b_last got=%h/%b want=%h/%b", op_out, overflow, er, ev);
    end
  endtask

  initial begin
    rst            = 1'b1;
    control_signal = 2'd0;
    a              = '0;
    b              = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
